// File: rtl/misr_session_ctrl.sv
// Session sequencer for a generic MISR: latches configuration on start,
// clears the MISR, enables it for exactly N accepted samples, requests
// completion, then captures and grades the final signature.
module misr_session_ctrl #(
  parameter int unsigned NBIT_DATA = 64,
  parameter int unsigned NBIT_CNT  = 32,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [NBIT_CNT-1:0]  num_samples_i,
  input  logic [NBIT_DATA-1:0] coeff_i,
  input  logic [NBIT_DATA-1:0] golden_i,
  input  logic                 sample_valid_i,
  input  logic [NBIT_DATA-1:0] misr_sig_i,
  input  logic                 misr_done_i,
  output logic                 misr_rst_no,
  output logic                 misr_en_o,
  output logic                 misr_done_o,
  output logic [NBIT_DATA-1:0] misr_coeff_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic                 timeout_o,
  output logic [NBIT_DATA-1:0] signature_o,
  output logic [NBIT_CNT-1:0]  sample_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    FLUSH,
    DONE
  } state_t;

  localparam int unsigned   TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [NBIT_CNT-1:0]  num_q;
  logic [NBIT_CNT-1:0]  cnt_q;
  logic [NBIT_DATA-1:0] coeff_q;
  logic [NBIT_DATA-1:0] golden_q;
  logic [NBIT_DATA-1:0] sig_q;
  logic [TW-1:0]        timer_q;
  logic                 pass_q, fail_q, timeout_q;

  logic idle_or_done;
  logic last_sample;
  logic timer_expired;

  // Shared decode terms for the FSM and the datapath
  always_comb begin
    idle_or_done  = (state_q == IDLE) || (state_q == DONE);
    last_sample   = (state_q == RUN) && sample_valid_i &&
                    (cnt_q == (num_q - NBIT_CNT'(1)));
    timer_expired = (timer_q == TIMER_LAST);
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: if (start_i) state_d = CLEAR;
        CLEAR:      state_d = (num_q == '0) ? FLUSH : RUN;
        RUN:        if (last_sample) state_d = FLUSH;
        FLUSH:      if (misr_done_i || timer_expired) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Moore output decode; only the MISR enable looks at the live valid
  always_comb begin
    misr_rst_no  = !((state_q == IDLE) || (state_q == CLEAR));
    misr_en_o    = (state_q == RUN) && sample_valid_i;
    misr_done_o  = (state_q == FLUSH);
    busy_o       = (state_q == CLEAR) || (state_q == RUN) || (state_q == FLUSH);
    done_o       = (state_q == DONE);
    pass_o       = pass_q;
    fail_o       = fail_q;
    timeout_o    = timeout_q;
    misr_coeff_o = coeff_q;
    signature_o  = sig_q;
    sample_cnt_o = cnt_q;
  end

  // FLUSH wait timer, restarts from zero on every entry to FLUSH
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                            timer_q <= '0;
    else if ((state_q == FLUSH) && !abort_i) timer_q <= timer_q + TW'(1);
    else                                    timer_q <= '0;
  end

  // Configuration latch, sample counter and result capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      num_q     <= '0;
      coeff_q   <= '0;
      golden_q  <= '0;
      cnt_q     <= '0;
      sig_q     <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // The counter follows exactly what the MISR was told to accept
      if (misr_en_o) cnt_q <= cnt_q + NBIT_CNT'(1);
      if (abort_i) begin
        pass_q    <= 1'b0;
        fail_q    <= 1'b0;
        timeout_q <= 1'b0;
      end else if (idle_or_done && start_i) begin
        num_q     <= num_samples_i;
        coeff_q   <= coeff_i;
        golden_q  <= golden_i;
        cnt_q     <= '0;
        sig_q     <= '0;
        pass_q    <= 1'b0;
        fail_q    <= 1'b0;
        timeout_q <= 1'b0;
      end else if (state_q == FLUSH) begin
        if (misr_done_i) begin
          sig_q  <= misr_sig_i;
          pass_q <= (misr_sig_i == golden_q);
          fail_q <= (misr_sig_i != golden_q);
        end else if (timer_expired) begin
          timeout_q <= 1'b1;
          fail_q    <= 1'b1;
          pass_q    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_misr_session_ctrl.sv
// Directed bench for misr_session_ctrl with a small MISR stand-in that
// compacts a constant datain of 1 (shift-left, feedback by coefficients).
module tb_misr_session_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [31:0] num;
  logic [63:0] coeff, golden;
  logic        valid;
  logic [63:0] misr_sig = '0;
  logic        misr_done = 1'b0;
  logic        done_en;
  logic        misr_rst_n, misr_en, misr_done_req;
  logic [63:0] misr_coeff, signature;
  logic        busy, done, pass, fail, tmo;
  logic [31:0] sample_cnt;

  int vectors = 0;
  int miscompares = 0;
  int en_count = 0;

  always #5 clk = ~clk;

  misr_session_ctrl #(.NBIT_DATA(64), .NBIT_CNT(32), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .num_samples_i(num), .coeff_i(coeff), .golden_i(golden),
    .sample_valid_i(valid), .misr_sig_i(misr_sig), .misr_done_i(misr_done),
    .misr_rst_no(misr_rst_n), .misr_en_o(misr_en), .misr_done_o(misr_done_req),
    .misr_coeff_o(misr_coeff), .busy_o(busy), .done_o(done), .pass_o(pass),
    .fail_o(fail), .timeout_o(tmo), .signature_o(signature),
    .sample_cnt_o(sample_cnt)
  );

  // MISR stand-in: done_out follows done_in one cycle later
  always @(posedge clk) begin
    if (misr_rst_n !== 1'b1) misr_sig <= '0;
    else if (misr_en === 1'b1)
      misr_sig <= {misr_sig[62:0], 1'b0} ^ (misr_sig[63] ? misr_coeff : 64'd0) ^ 64'd1;
    misr_done <= (misr_done_req === 1'b1) && done_en;
  end

  always @(posedge clk) if (misr_en === 1'b1) en_count++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  int n, base;
  logic [7:0] pat;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num = '0; coeff = '0;
    golden = '0; valid = 1'b0; done_en = 1'b1;
    repeat (3) step();
    chk("rst_misr_rst_n", misr_rst_n, 0);
    chk("rst_en", misr_en, 0);
    chk("rst_done_req", misr_done_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {pass, fail, tmo}, 0);
    chk("rst_coeff", misr_coeff, 0);
    chk("rst_sig", signature, 0);
    chk("rst_cnt", sample_cnt, 0);
    rst_n = 1'b1;
    step();

    // Session 1: 4 samples, continuous valid, expected signature 0xF
    start = 1'b1; num = 4; coeff = 64'h1B; golden = 64'hF; valid = 1'b1;
    base = en_count;
    step();
    start = 1'b0;
    chk("s1_clear_rst", misr_rst_n, 0);
    chk("s1_clear_busy", busy, 1);
    chk("s1_clear_en", misr_en, 0);
    step();
    chk("s1_run_rst", misr_rst_n, 1);
    chk("s1_run_en", misr_en, 1);
    chk("s1_coeff", misr_coeff, 64'h1B);
    wait_done(40, n);
    chk("s1_done", done, 1);
    chk("s1_en_count", en_count - base, 4);
    chk("s1_cnt", sample_cnt, 4);
    chk("s1_pass", pass, 1);
    chk("s1_fail", fail, 0);
    chk("s1_sig", signature, 64'hF);
    chk("s1_done_rst", misr_rst_n, 1);

    // Session 2: golden bit 0 flipped, restart straight from DONE
    start = 1'b1; golden = 64'hE;
    step();
    start = 1'b0;
    chk("s2_restart_done", done, 0);
    chk("s2_restart_pass", pass, 0);
    wait_done(40, n);
    chk("s2_done", done, 1);
    chk("s2_pass", pass, 0);
    chk("s2_fail", fail, 1);
    chk("s2_sig", signature, 64'hF);

    // Session 3: 5 samples with gapped valid, expected signature 0x1F
    pat = 8'b1101_1001;              // bit i is valid in RUN cycle i
    start = 1'b1; num = 5; golden = 64'h1F; valid = pat[0];
    base = en_count;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("s3_en_c%0d", i), misr_en, pat[i]);
      chk($sformatf("s3_run_c%0d", i), misr_done_req, 0);
      if (i < 7) valid = pat[i+1];
      step();
    end
    chk("s3_flush", misr_done_req, 1);
    chk("s3_flush_en", misr_en, 0);
    chk("s3_cnt", sample_cnt, 5);
    wait_done(40, n);
    chk("s3_en_count", en_count - base, 5);
    chk("s3_pass", pass, 1);
    chk("s3_sig", signature, 64'h1F);

    // Session 4: zero samples skips RUN, MISR reset value meets golden 0
    start = 1'b1; num = 0; golden = 64'h0; valid = 1'b1;
    base = en_count;
    step();
    start = 1'b0;
    step();
    chk("s4_flush", misr_done_req, 1);
    chk("s4_flush_en", misr_en, 0);
    wait_done(40, n);
    chk("s4_done", done, 1);
    chk("s4_en_count", en_count - base, 0);
    chk("s4_pass", pass, 1);
    chk("s4_sig", signature, 0);
    chk("s4_cnt", sample_cnt, 0);

    // Session 5: MISR never answers, FLUSH times out after 16 cycles
    done_en = 1'b0;
    start = 1'b1; num = 1; golden = 64'h1;
    step();
    start = 1'b0;
    step();
    step();
    chk("s5_flush", misr_done_req, 1);
    wait_done(100, n);
    chk("s5_flush_cycles", n, 16);
    chk("s5_done", done, 1);
    chk("s5_timeout", tmo, 1);
    chk("s5_fail", fail, 1);
    chk("s5_pass", pass, 0);
    chk("s5_sig", signature, 0);
    done_en = 1'b1;

    // Abort from DONE clears result flags, keeps configuration
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab1_done", done, 0);
    chk("ab1_flags", {pass, fail, tmo}, 0);
    chk("ab1_rst", misr_rst_n, 0);
    chk("ab1_coeff", misr_coeff, 64'h1B);

    // Abort in RUN after two accepted samples
    start = 1'b1; num = 10; valid = 1'b1;
    base = en_count;
    step();
    start = 1'b0;
    step();
    step();
    step();
    valid = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab2_rst", misr_rst_n, 0);
    chk("ab2_busy", busy, 0);
    chk("ab2_flags", {pass, fail, tmo}, 0);
    chk("ab2_en_count", en_count - base, 2);
    chk("ab2_cnt", sample_cnt, 2);

    // Restart with 3 samples; start pulses while busy must be ignored
    start = 1'b1; num = 3; golden = 64'h7; valid = 1'b1;
    base = en_count;
    step();
    start = 1'b0;
    step();
    start = 1'b1; num = 9; golden = 64'h0;
    step();
    step();
    start = 1'b0;
    chk("s6_busy", busy, 1);
    wait_done(40, n);
    chk("s6_done", done, 1);
    chk("s6_en_count", en_count - base, 3);
    chk("s6_cnt", sample_cnt, 3);
    chk("s6_pass", pass, 1);
    chk("s6_sig", signature, 64'h7);

    // Asynchronous reset in the middle of RUN
    start = 1'b1; num = 4; valid = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_en", misr_en, 0);
    chk("ar_rst", misr_rst_n, 0);
    chk("ar_cnt", sample_cnt, 0);
    chk("ar_coeff", misr_coeff, 0);
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
